universal_shift_reg: RTL

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 87 ++++++++
 1 files changed

// File: rtl/universal_shift_reg.sv
// Universal N-bit shift register: hold, shift right, shift left and parallel load.
// Also tracks same-direction shifts and pulses word_valid when a full N-bit frame has been shifted in.
module universal_shift_reg #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          si_r,
  input  logic          si_l,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          so_r,
  output logic          so_l,
  output logic [CW-1:0] bit_cnt,
  output logic          word_valid
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SR   = 2'b01;
  localparam logic [1:0] MODE_SL   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  localparam logic       DIR_RIGHT = 1'b0;
  localparam logic       DIR_LEFT  = 1'b1;

  logic [N-1:0]  q_p0;
  logic [CW-1:0] cnt_p0;
  logic          vld_p0;
  logic          dir_p0;

  logic          shift;
  logic          shift_dir;

  function automatic logic frame_end(input logic [CW-1:0] c);
    return c == CW'(N - 1);
  endfunction

  always_comb begin
    shift     = en && ((mode == MODE_SR) || (mode == MODE_SL));
    shift_dir = (mode == MODE_SL) ? DIR_LEFT : DIR_RIGHT;
  end

  // Stage p0: register contents, frame counter, direction flag and frame pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      q_p0   <= '0;
      cnt_p0 <= '0;
      vld_p0 <= 1'b0;
      dir_p0 <= DIR_RIGHT;
    end else begin
      vld_p0 <= 1'b0;
      if (en) begin
        case (mode)
          MODE_SR:   q_p0 <= {si_r, q_p0[N-1:1]};
          MODE_SL:   q_p0 <= {q_p0[N-2:0], si_l};
          MODE_LOAD: begin
            q_p0   <= d;
            cnt_p0 <= '0;
          end
          MODE_HOLD: q_p0 <= q_p0;
          default:   q_p0 <= q_p0;
        endcase
      end
      if (shift) begin
        dir_p0 <= shift_dir;
        // A reversal starts a new frame with this shift as its first bit
        if (shift_dir != dir_p0) begin
          cnt_p0 <= CW'(1);
        end else if (frame_end(cnt_p0)) begin
          cnt_p0 <= '0;
          vld_p0 <= 1'b1;
        end else begin
          cnt_p0 <= cnt_p0 + CW'(1);
        end
      end
    end
  end

  assign q          = q_p0;
  assign bit_cnt    = cnt_p0;
  assign word_valid = vld_p0;
  assign so_r       = q_p0[0];
  assign so_l       = q_p0[N-1];

endmodule
